// File: rtl/tero_meas_ctrl.sv
// rtl/tero_meas_ctrl.sv - TERO scan sequencer: index handshake, settle, edge-count window, result handshake
module tero_meas_ctrl #(
  parameter int N_TERO_BITS   = 32,
  parameter int N_TERO        = 16,
  parameter int CNT_BITS      = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_TERO_BITS-1:0] tero_sel_idx,
  input  logic                   tero_out,
  output logic                   tero_en,
  output logic                   sel_reset,
  output logic                   sel_increment,
  output logic                   meas_valid,
  input  logic                   meas_ready,
  output logic [N_TERO_BITS-1:0] meas_idx,
  output logic [CNT_BITS-1:0]    meas_count,
  output logic                   meas_sat,
  output logic                   busy,
  output logic                   done
);

  localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]          SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]          WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [N_TERO_BITS-1:0] LAST_IDX    = N_TERO_BITS'(N_TERO - 1);
  localparam logic [CNT_BITS-1:0]    CNT_MAX     = {CNT_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_REPORT  = 3'd4,
    S_ADVANCE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic                     sync1_q, sync2_q, edge_q;
  logic                     rise;
  logic [CNT_BITS-1:0]      edge_cnt_q, edge_cnt_d;
  logic                     edge_sat_q, edge_sat_d;

  logic                     tero_en_q, sel_reset_q, sel_increment_q;
  logic                     meas_valid_q, busy_q, done_q, meas_sat_q;
  logic [N_TERO_BITS-1:0]   meas_idx_q;
  logic [CNT_BITS-1:0]      meas_count_q;

  // tero_out is asynchronous; the third flop only remembers the previous synced level
  assign rise = sync2_q & ~edge_q;

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (start) state_d = S_INIT;
        S_INIT:    state_d = S_SETTLE;
        S_SETTLE:  if (timer_q == SETTLE_LAST) state_d = S_MEASURE;
        S_MEASURE: if (timer_q == WINDOW_LAST) state_d = S_REPORT;
        S_REPORT:  if (meas_ready) state_d = (meas_idx_q == LAST_IDX) ? S_DONE : S_ADVANCE;
        S_ADVANCE: state_d = S_SETTLE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Timer restarts at every state change, so SETTLE and MEASURE each run from zero
  always_comb begin
    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    edge_sat_d = edge_sat_q;
    if (state_q == S_SETTLE) begin
      edge_cnt_d = '0;
      edge_sat_d = 1'b0;
    end else if ((state_q == S_MEASURE) && rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        edge_sat_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= tero_out;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      edge_cnt_q      <= '0;
      edge_sat_q      <= 1'b0;
      tero_en_q       <= 1'b0;
      sel_reset_q     <= 1'b0;
      sel_increment_q <= 1'b0;
      meas_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      meas_idx_q      <= '0;
      meas_count_q    <= '0;
      meas_sat_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      edge_cnt_q      <= edge_cnt_d;
      edge_sat_q      <= edge_sat_d;
      tero_en_q       <= (state_d == S_SETTLE) || (state_d == S_MEASURE);
      sel_reset_q     <= (state_d == S_INIT);
      sel_increment_q <= (state_d == S_ADVANCE);
      meas_valid_q    <= (state_d == S_REPORT);
      busy_q          <= (state_d != S_IDLE);
      done_q          <= (state_d == S_DONE);
      if ((state_q == S_SETTLE) && (state_d == S_MEASURE)) begin
        meas_idx_q <= tero_sel_idx;
      end
      // Result includes a rise seen on the final window cycle
      if ((state_q == S_MEASURE) && (state_d == S_REPORT)) begin
        meas_count_q <= edge_cnt_d;
        meas_sat_q   <= edge_sat_d;
      end
    end
  end

  assign tero_en       = tero_en_q;
  assign sel_reset     = sel_reset_q;
  assign sel_increment = sel_increment_q;
  assign meas_valid    = meas_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign meas_idx      = meas_idx_q;
  assign meas_count    = meas_count_q;
  assign meas_sat      = meas_sat_q;

endmodule

// File: tb/tb_tero_meas_ctrl.sv
// tb/tb_tero_meas_ctrl.sv - directed table-driven bench for tero_meas_ctrl
module tb_tero_meas_ctrl;

  localparam int WIN = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic abort = 1'b0;
  logic meas_ready = 1'b1;
  logic tero_out = 1'b0;
  logic [31:0] idx1 = '0, idx2 = '0;

  logic        tero_en1, sel_reset1, sel_increment1, meas_valid1, meas_sat1, busy1, done1;
  logic [31:0] meas_idx1;
  logic [15:0] meas_count1;
  logic        tero_en2, sel_reset2, sel_increment2, meas_valid2, meas_sat2, busy2, done2;
  logic [31:0] meas_idx2;
  logic [3:0]  meas_count2;

  int n_cmp = 0;
  int n_bad = 0;
  int tero_period = 0;
  int ph = 0;

  always #5 clk = ~clk;

  tero_meas_ctrl #(.N_TERO_BITS(32), .N_TERO(4), .CNT_BITS(16), .SETTLE_CYCLES(4), .WINDOW_CYCLES(WIN)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .tero_sel_idx(idx1),
    .tero_out(tero_out), .tero_en(tero_en1), .sel_reset(sel_reset1), .sel_increment(sel_increment1),
    .meas_valid(meas_valid1), .meas_ready(meas_ready), .meas_idx(meas_idx1), .meas_count(meas_count1),
    .meas_sat(meas_sat1), .busy(busy1), .done(done1)
  );

  tero_meas_ctrl #(.N_TERO_BITS(32), .N_TERO(1), .CNT_BITS(4), .SETTLE_CYCLES(3), .WINDOW_CYCLES(WIN)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort), .tero_sel_idx(idx2),
    .tero_out(tero_out), .tero_en(tero_en2), .sel_reset(sel_reset2), .sel_increment(sel_increment2),
    .meas_valid(meas_valid2), .meas_ready(meas_ready), .meas_idx(meas_idx2), .meas_count(meas_count2),
    .meas_sat(meas_sat2), .busy(busy2), .done(done2)
  );

  // Index counter models
  always @(posedge clk) begin
    if (sel_reset1) idx1 <= '0;
    else if (sel_increment1) idx1 <= idx1 + 1;
    if (sel_reset2) idx2 <= '0;
    else if (sel_increment2) idx2 <= idx2 + 1;
  end

  always @(negedge clk) begin
    ph = ph + 1;
    if (tero_period == 0) tero_out = 1'b0;
    else tero_out = ((ph % tero_period) < (tero_period / 2));
  end

  function automatic int g_valid(int d);  return d == 1 ? int'(meas_valid1) : int'(meas_valid2); endfunction
  function automatic int g_idx(int d);    return d == 1 ? int'(meas_idx1) : int'(meas_idx2); endfunction
  function automatic int g_count(int d);  return d == 1 ? int'(meas_count1) : int'(meas_count2); endfunction
  function automatic int g_sat(int d);    return d == 1 ? int'(meas_sat1) : int'(meas_sat2); endfunction
  function automatic int g_rst(int d);    return d == 1 ? int'(sel_reset1) : int'(sel_reset2); endfunction
  function automatic int g_inc(int d);    return d == 1 ? int'(sel_increment1) : int'(sel_increment2); endfunction
  function automatic int g_done(int d);   return d == 1 ? int'(done1) : int'(done2); endfunction
  function automatic int g_busy(int d);   return d == 1 ? int'(busy1) : int'(busy2); endfunction
  function automatic int g_en(int d);     return d == 1 ? int'(tero_en1) : int'(tero_en2); endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 1) start1 = v; else start2 = v;
  endtask

  task automatic run_scan(input int d, input int period, input int n, input int exp_cnt,
                          input int exp_sat, input int extra_start);
    int cyc, nres, nrst, ninc, ndone, first_lat, settle;
    bit seen;
    settle = (d == 1) ? 4 : 3;
    cyc = 0; nres = 0; nrst = 0; ninc = 0; ndone = 0; first_lat = -1; seen = 0;
    tero_period = period;
    meas_ready = 1'b1;
    set_start(d, 1'b1);
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      set_start(d, 1'b0);
      cyc++;
      if (cyc == extra_start) set_start(d, 1'b1);
      nrst += g_rst(d);
      ninc += g_inc(d);
      if (g_valid(d) != 0) begin
        if (nres == 0) begin
          first_lat = cyc;
          chk("tero_en_in_report", g_en(d), 0);
        end
        chk($sformatf("dut%0d_p%0d_idx%0d", d, period, nres), g_idx(d), nres);
        chk($sformatf("dut%0d_p%0d_count%0d", d, period, nres), g_count(d), exp_cnt);
        chk($sformatf("dut%0d_p%0d_sat%0d", d, period, nres), g_sat(d), exp_sat);
        nres++;
      end
      if (g_done(d) != 0) begin
        ndone++;
        seen = 1;
      end
    end
    chk("scan_done_seen", int'(seen), 1);
    chk("result_count", nres, n);
    chk("sel_reset_pulses", nrst, 1);
    chk("sel_increment_pulses", ninc, n - 1);
    chk("done_pulses", ndone, 1);
    chk("first_latency", first_lat, 2 + settle + WIN);
    @(negedge clk);
    chk("busy_after_done", g_busy(d), 0);
    chk("done_one_cycle", g_done(d), 0);
    set_start(d, 1'b0);
  endtask

  typedef struct {
    int dut;
    int period;
    int n;
    int exp_cnt;
    int exp_sat;
    int extra_start;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int cyc;
    int cap_idx, cap_cnt, bad_hold, bad_any;

    tbl[0] = '{1, 10, 4, 10, 0, 0};
    tbl[1] = '{1, 20, 4, 5,  0, 15};
    tbl[2] = '{1, 4,  4, 25, 0, 0};
    tbl[3] = '{1, 2,  4, 50, 0, 0};
    tbl[4] = '{1, 0,  4, 0,  0, 0};
    tbl[5] = '{2, 2,  1, 15, 1, 0};
    tbl[6] = '{2, 10, 1, 10, 0, 50};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_tero_en", int'(tero_en1), 0);
    chk("rst_valid", int'(meas_valid1), 0);
    chk("rst_sel", int'(sel_reset1) + int'(sel_increment1) + int'(done1), 0);
    chk("rst_count", int'(meas_count1), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_scan(tbl[i].dut, tbl[i].period, tbl[i].n, tbl[i].exp_cnt, tbl[i].exp_sat, tbl[i].extra_start);
      repeat (2) @(negedge clk);
    end

    // Back-pressure in REPORT
    tero_period = 10;
    meas_ready = 1'b0;
    start1 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      cyc++;
    end while (!meas_valid1 && cyc < 400);
    chk("bp_valid_seen", int'(meas_valid1), 1);
    cap_idx = int'(meas_idx1);
    cap_cnt = int'(meas_count1);
    chk("bp_idx", cap_idx, 0);
    chk("bp_count", cap_cnt, 10);
    bad_hold = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!meas_valid1 || int'(meas_idx1) != cap_idx || int'(meas_count1) != cap_cnt ||
          tero_en1 || sel_increment1) bad_hold++;
    end
    chk("bp_hold_bad_cycles", bad_hold, 0);
    meas_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_cleared", int'(meas_valid1), 0);
    chk("bp_advance", int'(sel_increment1), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("bp_abort_idle", int'(busy1), 0);

    // Abort at MEASURE cycle 30
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    chk("ab_measuring", int'(tero_en1), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", int'(busy1), 0);
    chk("ab_tero_en", int'(tero_en1), 0);
    chk("ab_valid", int'(meas_valid1), 0);
    bad_any = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (meas_valid1 || done1 || busy1 || sel_increment1) bad_any++;
    end
    chk("ab_quiet_cycles", bad_any, 0);
    run_scan(1, 10, 4, 10, 0, 0);

    // Asynchronous reset mid-SETTLE
    @(negedge clk);
    start1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    chk("rs_in_settle", int'(tero_en1) + int'(busy1), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_busy", int'(busy1), 0);
    chk("rs_tero_en", int'(tero_en1), 0);
    chk("rs_count", int'(meas_count1), 0);
    chk("rs_idx", int'(meas_idx1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_scan(1, 10, 4, 10, 0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
